// File: rtl/reg_rename_unit_if.sv
// Rename-stage bundle: decode request, registered rename result, commit and flush.
// master = decode/commit side driving requests, slave = the rename unit.
interface reg_rename_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);

    logic          i_valid;
    logic [AW-1:0] i_rs;
    logic [AW-1:0] i_rt;
    logic          i_uses_rw;
    logic [AW-1:0] i_rw;
    logic          i_hold;
    logic          o_ready;
    logic          o_valid;
    logic [PW-1:0] o_rs_phys;
    logic [PW-1:0] o_rt_phys;
    logic [PW-1:0] o_rw_phys;
    logic [PW-1:0] o_rw_old_phys;
    logic          i_commit_valid;
    logic [AW-1:0] i_commit_rw;
    logic [PW-1:0] i_commit_phys;
    logic [PW-1:0] i_commit_old_phys;
    logic          i_flush;

    modport master (
        output i_valid, i_rs, i_rt, i_uses_rw, i_rw, i_hold,
        output i_commit_valid, i_commit_rw, i_commit_phys, i_commit_old_phys, i_flush,
        input  o_ready, o_valid, o_rs_phys, o_rt_phys, o_rw_phys, o_rw_old_phys
    );

    modport slave (
        input  i_valid, i_rs, i_rt, i_uses_rw, i_rw, i_hold,
        input  i_commit_valid, i_commit_rw, i_commit_phys, i_commit_old_phys, i_flush,
        output o_ready, o_valid, o_rs_phys, o_rt_phys, o_rw_phys, o_rw_old_phys
    );
endinterface

// File: rtl/reg_rename_unit.sv
// Single-issue register rename unit: speculative map + bit-vector free list,
// with a committed copy of both so a mispredict flush recovers in one cycle.
// Optional: define RENAME_FREE_COUNT_EN to add o_free_count, a registered
// count of free physical registers.
module reg_rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic clk,
    input  logic rst,
    reg_rename_if.slave rif
`ifdef RENAME_FREE_COUNT_EN
    ,
    output logic [$clog2(PHYS_REGS):0] o_free_count
`endif
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);

    // Arch regs start identity-mapped, so their phys slots start busy.
    localparam logic [PHYS_REGS-1:0] IN_USE_RST =
        {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};

    logic [ARCH_REGS-1:0][PW-1:0] spec_map, spec_map_nxt;
    logic [ARCH_REGS-1:0][PW-1:0] committed_map, committed_map_nxt;
    logic [PHYS_REGS-1:0]         in_use, in_use_nxt;
    logic [PHYS_REGS-1:0]         committed_in_use, committed_in_use_nxt;

    logic          alloc_needed;
    logic          any_free;
    logic [PW-1:0] free_idx;
    logic          accept;
    logic          do_alloc;
    logic          do_release;

    // Arch reg 0 is pinned to phys 0: never renamed, never freed.
    assign alloc_needed = rif.i_uses_rw & (rif.i_rw != '0);
    assign any_free     = ~&in_use;
    assign rif.o_ready  = ~rst & ~rif.i_hold & ~rif.i_flush & (~alloc_needed | any_free);
    assign accept       = rif.i_valid & rif.o_ready;
    assign do_alloc     = accept & alloc_needed;
    assign do_release   = rif.i_commit_valid & (rif.i_commit_old_phys != '0);

    // Lowest-index free physical register, from the pre-edge free list.
    always_comb begin
        free_idx = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (!in_use[i]) free_idx = PW'(i);
        end
    end

    // Committed state after this cycle's commit; also the flush restore image.
    always_comb begin
        committed_map_nxt    = committed_map;
        committed_in_use_nxt = committed_in_use;
        if (rif.i_commit_valid) begin
            committed_map_nxt[rif.i_commit_rw]      = rif.i_commit_phys;
            committed_in_use_nxt[rif.i_commit_phys] = 1'b1;
        end
        if (do_release) committed_in_use_nxt[rif.i_commit_old_phys] = 1'b0;
    end

    // Speculative state after this cycle's rename and release.
    // The allocated bit and the released bit never coincide.
    always_comb begin
        spec_map_nxt = spec_map;
        in_use_nxt   = in_use;
        if (do_alloc) begin
            spec_map_nxt[rif.i_rw] = free_idx;
            in_use_nxt[free_idx]   = 1'b1;
        end
        if (do_release) in_use_nxt[rif.i_commit_old_phys] = 1'b0;
    end

    // Map and free-list registers; flush overrides rename with committed image.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i]      <= PW'(i);
                committed_map[i] <= PW'(i);
            end
            in_use           <= IN_USE_RST;
            committed_in_use <= IN_USE_RST;
        end else begin
            committed_map    <= committed_map_nxt;
            committed_in_use <= committed_in_use_nxt;
            if (rif.i_flush) begin
                spec_map <= committed_map_nxt;
                in_use   <= committed_in_use_nxt;
            end else begin
                spec_map <= spec_map_nxt;
                in_use   <= in_use_nxt;
            end
        end
    end

    // Output register: lookups use the pre-update map so rs == rw sees old phys.
    always_ff @(posedge clk) begin
        if (rst) begin
            rif.o_valid       <= 1'b0;
            rif.o_rs_phys     <= '0;
            rif.o_rt_phys     <= '0;
            rif.o_rw_phys     <= '0;
            rif.o_rw_old_phys <= '0;
        end else if (rif.i_flush) begin
            rif.o_valid <= 1'b0;
        end else if (!rif.i_hold) begin
            if (accept) begin
                rif.o_valid       <= 1'b1;
                rif.o_rs_phys     <= spec_map[rif.i_rs];
                rif.o_rt_phys     <= spec_map[rif.i_rt];
                rif.o_rw_phys     <= alloc_needed ? free_idx : '0;
                rif.o_rw_old_phys <= alloc_needed ? spec_map[rif.i_rw] : '0;
            end else begin
                rif.o_valid <= 1'b0;
            end
        end
    end

`ifdef RENAME_FREE_COUNT_EN
    logic [PW:0] free_restore;

    // Free count implied by the post-commit committed free list.
    always_comb begin
        free_restore = '0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            if (!committed_in_use_nxt[i]) free_restore = free_restore + (PW+1)'(1);
        end
    end

    // Incremental free count, reloaded from the committed image on flush.
    always_ff @(posedge clk) begin
        if (rst)
            o_free_count <= (PW+1)'(PHYS_REGS - ARCH_REGS);
        else if (rif.i_flush)
            o_free_count <= free_restore;
        else
            o_free_count <= o_free_count + (PW+1)'(do_release) - (PW+1)'(do_alloc);
    end
`endif

endmodule

// File: tb/tb_reg_rename_unit.sv
// Bench for reg_rename_unit: vector table plus hand sequences for full,
// flush, hold and flush+commit corners; expected results via a queue.
module tb_reg_rename_unit;
    localparam int ARCH = 32;
    localparam int PHYS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_rename_if #(.ARCH_REGS(ARCH), .PHYS_REGS(PHYS)) rif ();

`ifdef RENAME_FREE_COUNT_EN
    logic [6:0] free_count;
`endif

    reg_rename_unit #(.ARCH_REGS(ARCH), .PHYS_REGS(PHYS)) dut (
        .clk(clk),
        .rst(rst),
        .rif(rif)
`ifdef RENAME_FREE_COUNT_EN
        ,
        .o_free_count(free_count)
`endif
    );

    typedef struct {
        logic [5:0] rs, rt, rw, old;
    } exp_t;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       u;
        logic [4:0] rw;
        logic       hold;
        logic       rdy;
        logic [5:0] ers, ert, erw, eold;
    } vec_t;

    exp_t queue_q[$];
    exp_t exp_last;
    logic exp_v_last;
    int   n_cmp = 0;
    int   n_err = 0;

    // Side-channel inputs for the next cycle; cleared after each cycle.
    logic       cm_v = 0;
    logic [4:0] cm_rw = 0;
    logic [5:0] cm_phys = 0, cm_old = 0;
    logic       fl = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rif.i_valid = 0; rif.i_rs = 0; rif.i_rt = 0; rif.i_uses_rw = 0; rif.i_rw = 0;
        rif.i_hold = 0; rif.i_commit_valid = 0; rif.i_commit_rw = 0;
        rif.i_commit_phys = 0; rif.i_commit_old_phys = 0; rif.i_flush = 0;
        #1 chk("rst_ready", rif.o_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", rif.o_valid, 0);
        chk("rst_outs", {rif.o_rs_phys, rif.o_rt_phys, rif.o_rw_phys, rif.o_rw_old_phys}, 0);
`ifdef RENAME_FREE_COUNT_EN
        chk("rst_free_count", free_count, PHYS - ARCH);
`endif
        rst = 1'b0;
        queue_q.delete();
        exp_v_last = 1'b0;
    endtask

    // One clock: drive request, check o_ready, push expected, check outputs.
    task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u, input logic [4:0] rw, input logic hold,
                       input logic rdy, input logic [5:0] ers, input logic [5:0] ert,
                       input logic [5:0] erw, input logic [5:0] eold);
        exp_t e;
        logic acc;
        rif.i_valid = v; rif.i_rs = rs; rif.i_rt = rt; rif.i_uses_rw = u; rif.i_rw = rw;
        rif.i_hold = hold;
        rif.i_commit_valid = cm_v; rif.i_commit_rw = cm_rw;
        rif.i_commit_phys = cm_phys; rif.i_commit_old_phys = cm_old;
        rif.i_flush = fl;
        #1 chk("ready", rif.o_ready, rdy);
        acc = v & rdy;
        if (acc) begin
            e.rs = ers; e.rt = ert; e.rw = erw; e.old = eold;
            queue_q.push_back(e);
        end
        @(posedge clk); #1;
        if (acc) begin
            chk("valid_after_accept", rif.o_valid, 1);
            if (queue_q.size() == 0) begin
                chk("queue_nonempty", 0, 1);
            end else begin
                e = queue_q.pop_front();
                chk("rs_phys", rif.o_rs_phys, e.rs);
                chk("rt_phys", rif.o_rt_phys, e.rt);
                chk("rw_phys", rif.o_rw_phys, e.rw);
                chk("rw_old_phys", rif.o_rw_old_phys, e.old);
                exp_last = e;
                exp_v_last = 1'b1;
            end
        end else if (!fl && hold) begin
            chk("held_valid", rif.o_valid, exp_v_last);
            if (exp_v_last) begin
                chk("held_rw_phys", rif.o_rw_phys, exp_last.rw);
                chk("held_rw_old", rif.o_rw_old_phys, exp_last.old);
            end
        end else begin
            chk("valid_idle", rif.o_valid, 0);
            exp_v_last = 1'b0;
        end
        cm_v = 0; cm_rw = 0; cm_phys = 0; cm_old = 0; fl = 0;
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 1, 2, 1, 3, 0, 1, 1, 2, 32, 3};
        tbl[1] = '{1, 0, 0, 1, 3, 0, 1, 0, 0, 33, 32};
        tbl[2] = '{1, 3, 3, 0, 3, 0, 1, 33, 33, 0, 0};
        tbl[3] = '{1, 3, 4, 1, 3, 0, 1, 33, 4, 34, 33};
        tbl[4] = '{1, 5, 3, 1, 0, 0, 1, 5, 34, 0, 0};
        tbl[5] = '{0, 7, 7, 1, 7, 0, 1, 0, 0, 0, 0};
        tbl[6] = '{1, 31, 0, 1, 31, 0, 1, 31, 0, 35, 31};

        // Basic renames from reset.
        do_reset();
        for (int i = 0; i < 7; i++)
            cyc(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].u, tbl[i].rw, tbl[i].hold,
                tbl[i].rdy, tbl[i].ers, tbl[i].ert, tbl[i].erw, tbl[i].eold);
`ifdef RENAME_FREE_COUNT_EN
        chk("free_count_after_table", free_count, 28);
`endif
        // Flush with nothing committed returns to identity mapping.
        fl = 1; cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 31, 1, 1, 0, 1, 3, 31, 32, 1);

        // Fill the free list, then release one.
        do_reset();
        for (int i = 0; i < 32; i++)
            cyc(1, 2, 5, 1, (i == 0) ? 5'd5 : 5'd1, 0, 1, 2, (i == 0) ? 6'd5 : 6'd32,
                6'(32 + i), (i == 0) ? 6'd5 : ((i == 1) ? 6'd1 : 6'(31 + i)));
`ifdef RENAME_FREE_COUNT_EN
        chk("free_count_full", free_count, 0);
`endif
        cyc(1, 2, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 0, 0, 1, 63, 2, 0, 0);
        cm_v = 1; cm_rw = 5; cm_phys = 32; cm_old = 5;
        cyc(1, 2, 2, 1, 2, 0, 0, 0, 0, 0, 0);
`ifdef RENAME_FREE_COUNT_EN
        chk("free_count_release", free_count, 1);
`endif
        cyc(1, 2, 2, 1, 2, 0, 1, 2, 2, 5, 2);
`ifdef RENAME_FREE_COUNT_EN
        chk("free_count_realloc", free_count, 0);
`endif

        // Commit + rename together, then flush to committed state.
        do_reset();
        cyc(1, 0, 0, 1, 3, 0, 1, 0, 0, 32, 3);
        cm_v = 1; cm_rw = 3; cm_phys = 32; cm_old = 3;
        cyc(1, 0, 0, 1, 3, 0, 1, 0, 0, 33, 32);
        fl = 1; cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 1, 32, 0, 0, 0);
        cyc(1, 0, 0, 1, 7, 0, 1, 0, 0, 3, 7);

        // Hold freezes output and blocks allocation.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 4, 0, 1, 0, 0, 33, 4);

        // Flush + commit + request in one cycle.
        cm_v = 1; cm_rw = 7; cm_phys = 3; cm_old = 7; fl = 1;
        cyc(1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
`ifdef RENAME_FREE_COUNT_EN
        chk("free_count_flush", free_count, 32);
`endif
        cyc(1, 7, 4, 1, 9, 0, 1, 3, 4, 7, 9);
`ifdef RENAME_FREE_COUNT_EN
        chk("free_count_post_flush", free_count, 31);
`endif
        chk("queue_drained", queue_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
